fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage that is the successor to the fixed single-cycle PC/instruction-memory path. It is the IF stage of the pipelined CPU.
- Owns the PC and the IF/ID pipeline register.
- Fetches through a ready/valid instruction-memory port that tolerates multi-cycle latency.
- Arbitrates exception, interrupt, branch/jump redirect and sequential PC, and tracks supervisor mode via PC[31].

Parameters:
- ADDR_W, 32, PC/address width; minimum 8.
- RESET_PC, 32'h8000_0000, PC after reset (supervisor).
- IRQ_VEC, 32'h8000_0004, interrupt handler entry.
- EXC_VEC, 32'h8000_0008, illegal-op handler entry.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous reset, active-low.
- stall  in  1  ID cannot accept; hold IF/ID register.
- redirect_valid  in  1  branch/jump/jr taken (from EX).
- redirect_pc  in  ADDR_W  redirect target.
- exc  in  1  illegal opcode detected in ID; one-cycle pulse.
- irq  in  1  level interrupt request.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address (= PC).
- imem_ready  in  1  memory accepts the request and returns imem_rdata in the same cycle.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  IF/ID slot holds a live entry.
- if_instr  out  32  instruction.
- if_pc  out  ADDR_W  PC of the slot; this is the EPC for interrupt slots.
- if_pc_plus4  out  ADDR_W  sequential successor of if_pc.
- if_irq  out  1  slot is an interrupt bubble (if_instr=0).
- kernel  out  1  PC[ADDR_W-1].

Behaviour:
- Reset (reset=0 at edge):
  - PC=RESET_PC; state=REQ.
  - if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, if_irq=0; irq_pending=0.
  - imem_req=0 during reset cycles.
  - Reset mid-transaction abandons any outstanding request; no data is captured.
- PC arithmetic:
  - Sequential next PC = {PC[ADDR_W-1], PC[ADDR_W-2:0]+4}. The top bit is preserved and the low field wraps modulo 2^(ADDR_W-1).
  - if_pc_plus4 uses the same rule.
  - Redirect/vector targets are loaded verbatim, so redirect_pc[MSB]=0 is the only way to leave supervisor mode.
- FSM states: REQ, DROP.
  - REQ: imem_req=1 unless (stall && if_valid). imem_addr=PC, held stable while imem_req && !imem_ready.
    - imem_ready && slot free (!if_valid || !stall): capture imem_rdata into IF/ID with if_pc=PC, if_valid=1; PC=next sequential.
  - DROP: entered when a PC change (redirect/exc/irq) occurs while imem_req && !imem_ready.
    - imem_req stays 1 with the old address until imem_ready; returned data is discarded; then return to REQ at the new PC.
    - PC already holds the new target.
  - Latency: with imem_ready tied 1 and no stall, one instruction per cycle; if_valid rises one cycle after the first request.
- Next-PC priority (per cycle, highest first):
  - reset > exc > irq accept > redirect_valid > sequential.
  - exc: PC=EXC_VEC; IF/ID flushed (if_valid=0).
  - redirect_valid: PC=redirect_pc; IF/ID flushed. Both override stall.
  - exc together with redirect_valid: exc wins, redirect lost.
- Interrupts:
  - irq_pending sets when irq=1 && !kernel.
  - Accepted at the first edge where irq_pending && !kernel && !exc && !redirect_valid && slot free.
  - On accept: IF/ID loads if_valid=1, if_irq=1, if_instr=0, if_pc=PC (next instruction to execute, i.e. return address); PC=IRQ_VEC; irq_pending clears.
  - The interrupt slot still counts as a normal slot for stall.
  - Interrupts are masked while kernel=1; pending state clears if irq drops before accept.
- Stall with if_valid=1: all if_* outputs hold; PC holds; no new request is issued. An outstanding request that completes under stall is treated as DROP data and re-fetched.
- Flush (exc/redirect) while imem_ready=1 in the same cycle: the returned data is dropped.

Test Plan:
- imem_ready=1, no events, reset released at RESET_PC → if_pc sequence 8000_0000, 8000_0004, 8000_0008 on consecutive cycles; if_valid=1 from cycle 2; kernel=1.
- redirect_valid=1, redirect_pc=0000_0040 at cycle 5 → next captured if_pc=0000_0040, one bubble (if_valid=0); kernel=0 thereafter.
- User mode at PC=0000_0100, irq=1 → slot with if_irq=1, if_instr=0, if_pc=0000_0100; next if_pc=8000_0004; second irq while kernel → ignored.
- exc and redirect_valid in the same cycle → PC=8000_0008, redirect target never fetched, irq pending not accepted that cycle.
- imem_ready low 3 cycles, redirect on cycle 1 → imem_addr stays on the old PC until ready, that data is discarded, next request address = redirect_pc.
- stall=1 for 4 cycles with if_valid=1, then reset=0 mid-stall → outputs frozen during stall; after reset all outputs are 0 and imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, fetches over a ready/valid
// memory port and arbitrates exception, interrupt, redirect and sequential PC.
`timescale 1ns/1ps
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000),
    parameter logic [ADDR_W-1:0] IRQ_VEC  = ADDR_W'(32'h8000_0004),
    parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(32'h8000_0008)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              exc,
    input  logic              irq,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic              if_irq,
    output logic              kernel
);

    localparam int unsigned LOW_W = ADDR_W - 1;

    typedef enum logic {S_REQ, S_DROP} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
    logic              outstanding_q, outstanding_d;
    logic              irq_pending_q, irq_pending_d;
    logic              if_valid_q, if_valid_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [ADDR_W-1:0] if_pc_plus4_q, if_pc_plus4_d;
    logic              if_irq_q, if_irq_d;

    logic slot_free;
    logic take_irq;
    logic pc_change;

    // Increment keeps the mode bit; only the low field wraps.
    function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1], a[LOW_W-1:0] + LOW_W'(4)};
    endfunction

    assign kernel    = pc_q[ADDR_W-1];
    assign slot_free = !if_valid_q || !stall;
    assign take_irq  = irq_pending_q && !kernel && !exc && !redirect_valid && slot_free;
    assign pc_change = exc || redirect_valid || take_irq;

    // A request already on the bus stays up (same address) until the memory accepts it.
    assign imem_req  = reset && ((state_q == S_DROP) || outstanding_q || slot_free);
    assign imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_irq      = if_irq_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_addr_d   = drop_addr_q;
        outstanding_d = imem_req && !imem_ready;
        irq_pending_d = irq && !kernel;
        if_valid_d    = if_valid_q && stall;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_irq_d      = if_irq_q;

        if ((state_q == S_REQ) && imem_ready && slot_free && !pc_change) begin
            if_valid_d    = 1'b1;
            if_instr_d    = imem_rdata;
            if_pc_d       = pc_q;
            if_pc_plus4_d = seq_pc(pc_q);
            if_irq_d      = 1'b0;
            pc_d          = seq_pc(pc_q);
        end

        if (exc) begin
            pc_d       = EXC_VEC;
            if_valid_d = 1'b0;
        end else if (take_irq) begin
            // Interrupt bubble carries the return address as its PC.
            if_valid_d    = 1'b1;
            if_instr_d    = 32'h0;
            if_pc_d       = pc_q;
            if_pc_plus4_d = seq_pc(pc_q);
            if_irq_d      = 1'b1;
            pc_d          = IRQ_VEC;
            irq_pending_d = 1'b0;
        end else if (redirect_valid) begin
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
        end

        if (pc_change && imem_req && !imem_ready) begin
            state_d     = S_DROP;
            drop_addr_d = imem_addr;
        end else if ((state_q == S_DROP) && imem_ready) begin
            state_d = S_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            drop_addr_q   <= '0;
            outstanding_q <= 1'b0;
            irq_pending_q <= 1'b0;
            if_valid_q    <= 1'b0;
            if_instr_q    <= 32'h0;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
            if_irq_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_addr_q   <= drop_addr_d;
            outstanding_q <= outstanding_d;
            irq_pending_q <= irq_pending_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_irq_q      <= if_irq_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scenario tasks with inline checks plus a scoreboard of
// IF/ID entries that ID consumes (if_valid && !stall).
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        exc = 1'b0;
    logic        irq = 1'b0;
    logic        ready_r = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_irq;
    logic        kernel;

    int n_tests = 0;
    int n_fail  = 0;
    logic mon_en = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5C3_0F1E;
    endfunction

    function automatic logic [31:0] plus4(input logic [31:0] a);
        return {a[31], a[30:0] + 31'd4};
    endfunction

    assign imem_ready = ready_r;
    assign imem_rdata = ready_r ? instr_of(imem_addr) : 32'hDEAD_BEEF;

    fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .exc(exc), .irq(irq),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4), .if_irq(if_irq), .kernel(kernel)
    );

    // Scoreboard: every entry ID takes must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en && if_valid && !stall) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb_unexpected: got entry if_pc=%h, required none", if_pc);
            end else begin
                mon_e = exp_q.pop_front();
                n_tests++;
                if (if_pc !== mon_e.pc) begin n_fail++; $display("FAIL sb_pc: got %h required %h", if_pc, mon_e.pc); end
                n_tests++;
                if (if_instr !== mon_e.instr) begin n_fail++; $display("FAIL sb_instr: got %h required %h", if_instr, mon_e.instr); end
                n_tests++;
                if (if_irq !== mon_e.irq) begin n_fail++; $display("FAIL sb_irq: got %b required %b", if_irq, mon_e.irq); end
                n_tests++;
                if (if_pc_plus4 !== plus4(mon_e.pc)) begin n_fail++; $display("FAIL sb_plus4: got %h required %h", if_pc_plus4, plus4(mon_e.pc)); end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic irq_slot);
        exp_t e;
        e.pc    = pc;
        e.instr = irq_slot ? 32'h0 : instr_of(pc);
        e.irq   = irq_slot;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        mon_en = 1'b0; reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; exc = 1'b0; irq = 1'b0; ready_r = 1'b1;
        exp_q.delete();
        tick(); tick();
    endtask

    // Freeze the stream and confirm every expected entry was consumed.
    task automatic end_test(input string name);
        stall = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL %s_drain: got %0d entries left, required 0", name, exp_q.size()); end
        mon_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", if_valid); end
        n_tests++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h required 0", if_instr); end
        n_tests++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h required 0", if_pc); end
        n_tests++; if (if_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL rst_plus4: got %h required 0", if_pc_plus4); end
        n_tests++; if (if_irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b required 0", if_irq); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b required 0", imem_req); end
        n_tests++; if (imem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_addr: got %h required 80000000", imem_addr); end
        n_tests++; if (kernel !== 1'b1) begin n_fail++; $display("FAIL rst_kernel: got %b required 1", kernel); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) push_exp(32'h8000_0000 + 32'(4 * i), 1'b0);
        reset = 1'b1; mon_en = 1'b1;
        #1;
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req: got %b required 1", imem_req); end
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL seq_first_valid: got %b required 0", if_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d: got %b required 1", i, if_valid); end
            n_tests++; if (if_pc !== 32'h8000_0000 + 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc%0d: got %h required %h", i, if_pc, 32'h8000_0000 + 32'(4 * i)); end
            n_tests++; if (kernel !== 1'b1) begin n_fail++; $display("FAIL seq_kernel%0d: got %b required 1", i, kernel); end
        end
        tick();
        end_test("seq");
    endtask

    task automatic test_redirect();
        do_reset();
        push_exp(32'h8000_0000, 1'b0); push_exp(32'h8000_0004, 1'b0);
        push_exp(32'h8000_0008, 1'b0); push_exp(32'h0000_0040, 1'b0);
        reset = 1'b1; mon_en = 1'b1;
        tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble: got %b required 0", if_valid); end
        n_tests++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_addr: got %h required 00000040", imem_addr); end
        n_tests++; if (kernel !== 1'b0) begin n_fail++; $display("FAIL redir_kernel: got %b required 0", kernel); end
        tick();
        n_tests++; if (if_pc !== 32'h40) begin n_fail++; $display("FAIL redir_pc: got %h required 00000040", if_pc); end
        tick();
        end_test("redir");
    endtask

    task automatic test_irq();
        do_reset();
        push_exp(32'h0000_0100, 1'b1); push_exp(32'h8000_0004, 1'b0);
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; mon_en = 1'b1;
        tick();
        redirect_valid = 1'b0; irq = 1'b1; ready_r = 1'b0;
        n_tests++; if (kernel !== 1'b0) begin n_fail++; $display("FAIL irq_user: got %b required 0", kernel); end
        tick();
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL irq_wait_valid: got %b required 0", if_valid); end
        tick();
        n_tests++; if (if_irq !== 1'b1) begin n_fail++; $display("FAIL irq_slot: got %b required 1", if_irq); end
        n_tests++; if (if_pc !== 32'h100) begin n_fail++; $display("FAIL irq_epc: got %h required 00000100", if_pc); end
        n_tests++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL irq_instr: got %h required 0", if_instr); end
        n_tests++; if (kernel !== 1'b1) begin n_fail++; $display("FAIL irq_kernel: got %b required 1", kernel); end
        ready_r = 1'b1;
        tick();
        n_tests++; if (imem_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL irq_vec_addr: got %h required 80000004", imem_addr); end
        tick();
        n_tests++; if (if_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL irq_vec_pc: got %h required 80000004", if_pc); end
        tick();
        n_tests++; if (if_irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b required 0", if_irq); end
        end_test("irq");
        irq = 1'b0;
    endtask

    task automatic test_exc_priority();
        do_reset();
        push_exp(32'h0000_0200, 1'b0); push_exp(32'h8000_0008, 1'b0);
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; mon_en = 1'b1;
        tick();
        redirect_valid = 1'b0; irq = 1'b1;
        tick();
        exc = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        tick();
        exc = 1'b0; redirect_valid = 1'b0; irq = 1'b0;
        n_tests++; if (imem_addr !== 32'h8000_0008) begin n_fail++; $display("FAIL exc_addr: got %h required 80000008", imem_addr); end
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL exc_flush: got %b required 0", if_valid); end
        n_tests++; if (kernel !== 1'b1) begin n_fail++; $display("FAIL exc_kernel: got %b required 1", kernel); end
        tick();
        n_tests++; if (if_irq !== 1'b0) begin n_fail++; $display("FAIL exc_no_irq: got %b required 0", if_irq); end
        tick();
        end_test("exc");
    endtask

    task automatic test_drop();
        do_reset();
        push_exp(32'h8000_0000, 1'b0); push_exp(32'h8000_0004, 1'b0); push_exp(32'h0000_0080, 1'b0);
        reset = 1'b1; mon_en = 1'b1;
        tick(); tick();
        ready_r = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (imem_addr !== 32'h8000_0008 || imem_req !== 1'b1) begin n_fail++; $display("FAIL drop_hold%0d: got req=%b addr=%h required req=1 addr=80000008", i, imem_req, imem_addr); end
            if (i < 2) tick();
        end
        ready_r = 1'b1;
        tick();
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL drop_discard: got %b required 0", if_valid); end
        n_tests++; if (imem_addr !== 32'h80) begin n_fail++; $display("FAIL drop_newaddr: got %h required 00000080", imem_addr); end
        tick();
        n_tests++; if (if_instr !== instr_of(32'h80)) begin n_fail++; $display("FAIL drop_instr: got %h required %h", if_instr, instr_of(32'h80)); end
        tick();
        end_test("drop");
    endtask

    task automatic test_wrap();
        do_reset();
        push_exp(32'hFFFF_FFFC, 1'b0); push_exp(32'h8000_0000, 1'b0);
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; mon_en = 1'b1;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_tests++; if (if_pc_plus4 !== 32'h8000_0000) begin n_fail++; $display("FAIL wrap_plus4: got %h required 80000000", if_pc_plus4); end
        n_tests++; if (imem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL wrap_addr: got %h required 80000000", imem_addr); end
        tick(); tick();
        end_test("wrap");
    endtask

    task automatic test_stall_reset();
        do_reset();
        push_exp(32'h8000_0000, 1'b0);
        reset = 1'b1; mon_en = 1'b1;
        tick(); tick();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0004 || if_instr !== instr_of(32'h8000_0004) || if_pc_plus4 !== 32'h8000_0008)
                begin n_fail++; $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h p4=%h required v=1 pc=80000004", i, if_valid, if_pc, if_instr, if_pc_plus4); end
            n_tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h8000_0008) begin n_fail++; $display("FAIL stall_req%0d: got req=%b addr=%h required req=0 addr=80000008", i, imem_req, imem_addr); end
        end
        reset = 1'b0;
        tick();
        n_tests++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || if_pc_plus4 !== 32'h0 || if_irq !== 1'b0)
            begin n_fail++; $display("FAIL stall_rst_out: got v=%b pc=%h instr=%h p4=%h irq=%b required all 0", if_valid, if_pc, if_instr, if_pc_plus4, if_irq); end
        n_tests++; if (imem_addr !== 32'h8000_0000 || imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_rst_addr: got req=%b addr=%h required req=0 addr=80000000", imem_req, imem_addr); end
        end_test("stallrst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_irq();
        test_exc_priority();
        test_drop();
        test_wrap();
        test_stall_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
